// File: rtl/vid_pkg.sv
// Shared types and constants for the video frame-buffer read path.
package vid_pkg;

  localparam int unsigned PIX_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FETCH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [PIX_W-1:0] UNDERFLOW_PIX_DEF = 24'hFF00FF;

endpackage

// File: rtl/vid_pix_fifo.sv
// Synchronous pixel FIFO with occupancy count and synchronous flush.
module vid_pix_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_rdata_c,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Guard against writing when full or reading when empty; flush overrides both.
  always_comb begin
    w_push = i_push && !i_flush && (r_count != CW'(DEPTH));
    w_pop  = i_pop  && !i_flush && (r_count != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage is not reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata_c = r_mem[r_rptr];
  assign o_count   = r_count;

endmodule

// File: rtl/vid_line_fetch.sv
// Line-by-line frame-buffer fetcher: requests lines from the DDR2 read port and streams pixels on vid_de.
module vid_line_fetch
  import vid_pkg::*;
#(
  parameter int unsigned      ACTIVE_W      = 1280,
  parameter int unsigned      ACTIVE_H      = 720,
  parameter int unsigned      FIFO_DEPTH    = 64,
  parameter logic [PIX_W-1:0] UNDERFLOW_PIX = UNDERFLOW_PIX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vid_vs,
  input  logic             vid_de,
  output logic             local_rd_req,
  output logic             local_rd_ready,
  input  logic [PIX_W-1:0] local_rd_data,
  input  logic             local_rd_valid,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_valid,
  output logic             underflow,
  output logic             overflow
);

  localparam int unsigned RCV_W  = $clog2(ACTIVE_W + 1);
  localparam int unsigned LINE_W = $clog2(ACTIVE_H + 1);
  localparam int unsigned CW     = $clog2(FIFO_DEPTH + 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [RCV_W-1:0]  r_rcv_cnt;
  logic [LINE_W-1:0] r_line_cnt;
  logic              r_rd_req;
  logic              r_rd_ready;
  logic [PIX_W-1:0]  r_pix_data;
  logic              r_pix_valid;
  logic              r_underflow;
  logic              r_overflow;

  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_count_nxt;
  logic [PIX_W-1:0]  w_fifo_rdata;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_rcv_last;
  logic              w_ready_nxt;

  vid_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (vid_vs),
    .i_push    (w_push),
    .i_wdata   (local_rd_data),
    .i_pop     (w_pop),
    .o_rdata_c (w_fifo_rdata),
    .o_count   (w_count)
  );

  // Next state, FIFO handshake and next-cycle ready (ready tracks the post-edge occupancy).
  always_comb begin
    w_full      = (w_count == CW'(FIFO_DEPTH));
    w_empty     = (w_count == '0);
    w_push      = local_rd_valid && (r_state == FETCH) && !w_full && !vid_vs;
    w_pop       = vid_de && !w_empty && !vid_vs;
    w_rcv_last  = w_push && (r_rcv_cnt == RCV_W'(ACTIVE_W - 1));
    w_state_nxt = r_state;
    if (vid_vs) begin
      w_state_nxt = REQ;
    end else begin
      case (r_state)
        REQ:     w_state_nxt = FETCH;
        FETCH:   if (w_rcv_last) w_state_nxt = (r_line_cnt == LINE_W'(ACTIVE_H)) ? DONE : REQ;
        default: w_state_nxt = r_state;
      endcase
    end
    w_count_nxt = vid_vs ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
    w_ready_nxt = (w_state_nxt == FETCH) && ((CW'(FIFO_DEPTH) - w_count_nxt) >= CW'(2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rcv_cnt   <= '0;
      r_line_cnt  <= '0;
      r_rd_req    <= 1'b0;
      r_rd_ready  <= 1'b0;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_req   <= (w_state_nxt == REQ);
      r_rd_ready <= w_ready_nxt;
      if (vid_vs) begin
        r_rcv_cnt  <= '0;
        r_line_cnt <= '0;
      end else begin
        if (r_state == REQ) r_line_cnt <= r_line_cnt + LINE_W'(1);
        if (w_push)         r_rcv_cnt  <= w_rcv_last ? '0 : (r_rcv_cnt + RCV_W'(1));
      end
      r_pix_valid <= vid_de;
      if (vid_de) r_pix_data <= w_pop ? w_fifo_rdata : UNDERFLOW_PIX;
      // Sticky error flags; a frame start clears them and suppresses setting that cycle.
      if (vid_vs) begin
        r_underflow <= 1'b0;
        r_overflow  <= 1'b0;
      end else begin
        if (vid_de && w_empty) r_underflow <= 1'b1;
        if (local_rd_valid && ((r_state != FETCH) || w_full)) r_overflow <= 1'b1;
      end
    end
  end

  assign local_rd_req   = r_rd_req;
  assign local_rd_ready = r_rd_ready;
  assign pix_data       = r_pix_data;
  assign pix_valid      = r_pix_valid;
  assign underflow      = r_underflow;
  assign overflow       = r_overflow;

endmodule
